serial_tx_arbiter: RTL
======================

# serial_tx_arbiter

Round-robin arbiter that shares the single `quick_rs232` transmit channel between `NUM_REQ` byte producers (echo path, status reporter, debug dumper). It sits between the requesters and the `quick_rs232` TX-side ports. It owns the full `tx_transaction` / `tx_data_ready` / `tx_data_copied` handshake, so producers only see a simple req/ack byte interface.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `HOLD_CYCLES`, 10: length in cycles of each of the HOLD and FIN phases, 1..255.
- `TIMEOUT_CYCLES`, 1000000: limit on waiting for `tx_data_copied`. Used only with `SERIAL_TX_ARB_TIMEOUT_EN`.

Ports:
- `clk`, in, 1: single clock, 50 MHz on the board.
- `rst`, in, 1: reset, synchronous, active-high.
- `req`, in, NUM_REQ: per-requester "byte pending"; level-sensitive.
- `req_data`, in, NUM_REQ*8: byte of requester i at bits [8i+7:8i].
- `ack`, out, NUM_REQ: one-hot, one-cycle pulse; the byte of requester i has been latched.
- `arb_busy`, out, 1: high in every state except IDLE.
- `tx_transaction`, out, 1: to `quick_rs232`.
- `tx_data`, out, 8: to `quick_rs232`.
- `tx_data_ready`, out, 1: to `quick_rs232`.
- `tx_data_copied`, in, 1: from `quick_rs232`.
- `tx_busy`, in, 1: from `quick_rs232`.
- `timeout_err`, out, 1: one-cycle pulse on handshake abort. Constant 0 without the macro.

## Operation
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Round-robin pointer `last` = NUM_REQ-1, so requester 0 has first priority.
  - Counters 0.
- **IDLE**: when `tx_busy`=0 and `req`≠0, the arbiter selects the first set bit searching from `last+1` upward, wrapping modulo NUM_REQ. On that edge it:
  - latches the selected byte into `tx_data`;
  - sets `last` to the winner;
  - pulses `ack[winner]`;
  - sets `tx_transaction`=1 and `tx_data_ready`=1;
  - moves to LOAD.
- **LOAD**: holds outputs. On `tx_data_copied`=1, moves to DROP.
- **DROP**: on `tx_data_copied`=0, clears the counter and moves to HOLD.
- **HOLD**: counts HOLD_CYCLES cycles. On the last cycle it clears `tx_data_ready`, clears the counter and moves to FIN.
- **FIN**: counts HOLD_CYCLES cycles. On the last cycle it clears `tx_transaction` and moves to IDLE.
- Requesters must deassert `req` on the cycle after `ack`. A `req` still high when IDLE is re-entered is treated as a new byte.
- `req_data` is sampled only on the grant edge. Changes at any other time are ignored.
- Changes to `req` outside IDLE have no effect. Pending requests simply wait.
- `tx_data` stays stable from grant until the next grant.

## Timing
- Grant latency: `ack` and `tx_data_ready` rise on the first edge after `req` is seen with `tx_busy`=0. That is 1 cycle.
- Minimum arbiter occupancy per byte is 2+2·HOLD_CYCLES cycles plus the `quick_rs232` copy time: LOAD≥1, DROP≥1, HOLD=FIN=HOLD_CYCLES each.
- Back-to-back grants: the earliest next `ack` is the cycle after FIN exits. IDLE lasts at least 1 cycle.
- Fairness: if several requesters hold `req` continuously, grants rotate strictly. With all 4 requesters active from reset, grant order is 0,1,2,3,0…
- `tx_busy`=1 in IDLE blocks the grant. The arbiter grants on the first cycle `tx_busy` reads 0.
- Reset mid-handshake: the next edge returns all outputs and state to reset values and drops the in-flight byte. No `ack` is re-issued.

## Configuration
- `SERIAL_TX_ARB_TIMEOUT_EN` defined:
  - A 32-bit counter runs in LOAD and DROP and clears on entry to LOAD.
  - Reaching TIMEOUT_CYCLES in either state forces `tx_data_ready`=0 and `tx_transaction`=0, pulses `timeout_err` for 1 cycle, and returns to IDLE.
  - The byte is dropped and `last` is kept, so the aborted requester does not retry before the others.
- Not defined: no counter, and `timeout_err` is tied to 0. LOAD and DROP wait indefinitely.

## Test plan
- **Single request**: reset, then `req`=4'b0010 with byte 0x41. Expect:
  - `ack`=4'b0010 for 1 cycle;
  - `tx_data`=0x41 and `tx_data_ready`=1;
  - after the model pulses `tx_data_copied` 3 cycles, `tx_data_ready` falls exactly 10 cycles after copied falls;
  - `tx_transaction` falls 10 cycles later.
- **Round robin**: all 4 requesters held high with bytes 0x10,0x11,0x12,0x13 and re-requesting after each ack. Expect 8 transmitted bytes in order 0x10,0x11,0x12,0x13,0x10,0x11,0x12,0x13.
- **Wrap priority**: last grant was 3; assert `req`=4'b1001. Expect requester 0 to be granted first, then requester 3.
- **tx_busy gating**: hold `tx_busy`=1 for 50 cycles while `req`=4'b0001. Expect no `ack` during those cycles; `ack` comes 1 cycle after `tx_busy`=0.
- **Reset mid-transfer**: assert `rst` in HOLD. Expect all outputs 0 on the next edge. After reset is released, a pending `req`=4'b0100 is granted within 2 cycles.
- **Timeout**: with the macro defined and TIMEOUT_CYCLES=100, never assert `tx_data_copied`. Expect:
  - `timeout_err` pulses 100 cycles after grant;
  - `tx_data_ready` and `tx_transaction` read 0 by that cycle;
  - the next pending requester is granted afterwards.

Source files
------------

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one quick_rs232 transmit channel among NUM_REQ byte producers.
// Define SERIAL_TX_ARB_TIMEOUT_EN to abort a handshake stuck waiting on tx_data_copied.
module serial_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int HOLD_CYCLES    = 10,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 arb_busy,
  output logic                 tx_transaction,
  output logic [7:0]           tx_data,
  output logic                 tx_data_ready,
  input  logic                 tx_data_copied,
  input  logic                 tx_busy,
  output logic                 timeout_err
);

  localparam int         IDX_W     = $clog2(NUM_REQ);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("serial_tx_arbiter: NUM_REQ must be 2..8");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("serial_tx_arbiter: HOLD_CYCLES must be 1..255");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("serial_tx_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DROP,
    S_HOLD,
    S_FIN
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [7:0]         hold_cnt_q, hold_cnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               tx_trans_q, tx_trans_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_rdy_q, tx_rdy_d;

  logic               grant_vld;
  logic [IDX_W-1:0]   grant_idx;

`ifdef SERIAL_TX_ARB_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] to_cnt_q, to_cnt_d;
  logic        terr_q, terr_d;
`endif

  // Rotating search: first pending requester strictly after the previous winner.
  always_comb begin : pick
    logic [IDX_W:0] cand;
    grant_vld = 1'b0;
    grant_idx = last_q;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!grant_vld && req[cand[IDX_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    ack_d      = '0;
    tx_trans_d = tx_trans_q;
    tx_data_d  = tx_data_q;
    tx_rdy_d   = tx_rdy_q;
`ifdef SERIAL_TX_ARB_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
    terr_d     = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (!tx_busy && grant_vld) begin
          tx_data_d         = req_data[{grant_idx, 3'b000} +: 8];
          last_d            = grant_idx;
          ack_d[grant_idx]  = 1'b1;
          tx_trans_d        = 1'b1;
          tx_rdy_d          = 1'b1;
          state_d           = S_LOAD;
`ifdef SERIAL_TX_ARB_TIMEOUT_EN
          to_cnt_d          = '0;
`endif
        end
      end
      S_LOAD: begin
        if (tx_data_copied) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (!tx_data_copied) begin
          hold_cnt_d = '0;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          tx_rdy_d   = 1'b0;
          hold_cnt_d = '0;
          state_d    = S_FIN;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      S_FIN: begin
        if (hold_cnt_q == HOLD_LAST) begin
          tx_trans_d = 1'b0;
          hold_cnt_d = '0;
          state_d    = S_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef SERIAL_TX_ARB_TIMEOUT_EN
    // The abort overrides any copy progress seen on the same edge; last is kept.
    if (state_q == S_LOAD || state_q == S_DROP) begin
      if (to_cnt_q == TO_LAST) begin
        state_d    = S_IDLE;
        tx_rdy_d   = 1'b0;
        tx_trans_d = 1'b0;
        terr_d     = 1'b1;
        to_cnt_d   = '0;
      end else begin
        to_cnt_d = to_cnt_q + 32'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_q     <= IDX_W'(NUM_REQ - 1);
      hold_cnt_q <= '0;
      ack_q      <= '0;
      tx_trans_q <= 1'b0;
      tx_data_q  <= '0;
      tx_rdy_q   <= 1'b0;
`ifdef SERIAL_TX_ARB_TIMEOUT_EN
      to_cnt_q   <= '0;
      terr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      ack_q      <= ack_d;
      tx_trans_q <= tx_trans_d;
      tx_data_q  <= tx_data_d;
      tx_rdy_q   <= tx_rdy_d;
`ifdef SERIAL_TX_ARB_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
      terr_q     <= terr_d;
`endif
    end
  end

  assign ack            = ack_q;
  assign arb_busy       = (state_q != S_IDLE);
  assign tx_transaction = tx_trans_q;
  assign tx_data        = tx_data_q;
  assign tx_data_ready  = tx_rdy_q;
`ifdef SERIAL_TX_ARB_TIMEOUT_EN
  assign timeout_err    = terr_q;
`else
  assign timeout_err    = 1'b0;
`endif

endmodule
